ctrl_disco: RTL
===============

# ctrl_disco

Disk transfer sequencer for the multicycle processor: when the control unit issues `ldisk`/`sdisk`, this block copies a block of words between disk storage and main data memory. It requests the shared memory port from the memory arbiter, moves one word every two cycles while granted, pauses at word boundaries when the grant is revoked, and pulses completion back to the control unit, which stalls while `ocupado` is high.

## Interface
- `ADDR_W`, 10: main memory address width.
- `DISK_W`, 16: disk address width.
- `DATA_W`, 32: word width.
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start request from the control unit, sampled in OCIOSO only.
- `direcao`  in  1  0 = ldisk (disk→memory), 1 = sdisk (memory→disk); latched at start.
- `end_mem`  in  ADDR_W  memory base address; latched at start.
- `end_disco`  in  DISK_W  disk base address; latched at start.
- `tamanho`  in  8  word count, 0–255; latched at start.
- `ocupado`  out  1  high from the cycle after start until the FIM cycle, inclusive.
- `concluido`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  request for the memory port.
- `mem_gnt`  in  1  grant from the memory arbiter.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; synchronous, valid one cycle after the address.
- `disk_addr`  out  DISK_W  disk address.
- `disk_we`  out  1  disk write enable.
- `disk_wdata`  out  DATA_W  disk write data.
- `disk_rdata`  in  DATA_W  disk read data; synchronous, one-cycle latency.

## Operation
- States: OCIOSO, ESPERA_GNT, LER, ESCREVE, FIM. Outputs are Moore, decoded from the state and the registers.
- OCIOSO:
  - On `iniciar`=1, latch `direcao`, `end_mem`, `end_disco` and `tamanho`, and clear `offset`.
  - If `tamanho`=0, go to FIM. Otherwise set `restante`=`tamanho` and go to ESPERA_GNT.
  - `iniciar` is ignored in every other state.
- ESPERA_GNT:
  - `mem_req`=1, no access.
  - If `mem_gnt`=1, go to LER; else stay.
- LER:
  - `mem_req`=1.
  - Drive the source address, base+`offset`: `disk_addr` when ldisk, `mem_addr` when sdisk.
  - Next state: ESCREVE.
- ESCREVE:
  - `mem_req`=1.
  - Drive the destination address, base+`offset`. Destination write enable = 1. Destination wdata = source rdata, passed through combinationally.
  - Update `offset`+1 and `restante`−1.
  - Next state: FIM if `restante`=1, else LER if `mem_gnt`=1, else ESPERA_GNT.
- FIM: `concluido`=1, `mem_req`=0, then go to OCIOSO.
- Address arithmetic: base+`offset` is computed modulo 2^ADDR_W for memory and modulo 2^DISK_W for disk; wrap-around is silent.
- Arbiter contract:
  - `mem_gnt` is sampled only in ESPERA_GNT and ESCREVE.
  - The arbiter does not revoke the grant between LER and ESCREVE of the same word.
- When not actively addressed: addresses hold their last driven value, write enables are 0, and wdata is 0.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - State OCIOSO.
  - `ocupado`, `concluido`, `mem_req`, `mem_we`, `disk_we` = 0.
  - `mem_addr`, `disk_addr`, `mem_wdata`, `disk_wdata` = 0.
  - `offset`, `restante` = 0.
- Start edge = cycle 0. ESPERA_GNT occupies cycle 1, with `mem_req` and `ocupado` high.
- With `mem_gnt` held high:
  - Word k uses LER in cycle 2+2k and ESCREVE in cycle 3+2k.
  - FIM in cycle 2N+2, where `concluido` pulses.
  - Total latency 2N+2 cycles.
- Each cycle with `mem_gnt` low at a sample point adds one ESPERA_GNT cycle. No word is ever split or repeated.
- `tamanho`=0: FIM in cycle 1. `concluido` pulses, `mem_req` never rises, no access occurs.
- Reset mid-transfer: immediate return to OCIOSO with all outputs at reset values. Words already written stay written; no `concluido` is generated.
- `iniciar` during FIM is ignored. A new start is accepted from OCIOSO, at the earliest one cycle after the FIM cycle.

## Test plan
- ldisk, `tamanho`=4, `end_disco`=0x0100, `end_mem`=0x020, `mem_gnt`=1 → memory 0x020–0x023 hold disk 0x0100–0x0103; `concluido` in cycle 10; four `mem_we` pulses.
- sdisk, `tamanho`=3, `end_mem`=0x3FE, `end_disco`=0xFFFF → reads memory 0x3FE, 0x3FF, 0x000 and writes disk 0xFFFF, 0x0000, 0x0001; `concluido` in cycle 8.
- ldisk, `tamanho`=3, `mem_gnt` low for 2 cycles after the word-0 ESCREVE → two extra ESPERA_GNT cycles; `concluido` in cycle 10; data correct; no access while waiting.
- `tamanho`=0 → `concluido` in cycle 1, `mem_req` stays 0, no `mem_we`/`disk_we`.
- `reset` low during word-2 LER of an 8-word ldisk → all outputs 0 immediately; memory holds words 0–1 only; a restart with `tamanho`=1 completes in cycle 4.
- `iniciar` pulsed while `ocupado` with different operands → ignored; the first transfer completes unchanged with exactly one `concluido`.

Source files
------------

// File: rtl/ctrl_disco.sv
// ctrl_disco -- disk transfer sequencer.
//
// Copies a block of words between disk storage and main data memory when
// the control unit issues ldisk/sdisk. The shared memory port is requested
// from the arbiter. While the grant is held, one word moves every two
// cycles: LER drives the source address, and ESCREVE writes the
// destination. The sequencer only pauses on a word boundary, so a word is
// never split or repeated.
//
// Ports:
//   clk_i, reset_i          clock; asynchronous active-low reset
//   iniciar_i               start request (sampled in OCIOSO only)
//   direcao_i               0 = ldisk (disk->mem), 1 = sdisk (mem->disk)
//   end_mem_i, end_disco_i  memory / disk base addresses
//   tamanho_i               word count (0..255)
//   ocupado_o, concluido_o  busy flag / one-cycle completion pulse
//   mem_req_o, mem_gnt_i    memory port request / arbiter grant
//   mem_addr_o, mem_we_o, mem_wdata_o, mem_rdata_i      memory port
//   disk_addr_o, disk_we_o, disk_wdata_o, disk_rdata_i  disk port
module ctrl_disco #(
    parameter int ADDR_W = 10,
    parameter int DISK_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              iniciar_i,
    input  logic              direcao_i,
    input  logic [ADDR_W-1:0] end_mem_i,
    input  logic [DISK_W-1:0] end_disco_i,
    input  logic [7:0]        tamanho_i,
    output logic              ocupado_o,
    output logic              concluido_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DISK_W-1:0] disk_addr_o,
    output logic              disk_we_o,
    output logic [DATA_W-1:0] disk_wdata_o,
    input  logic [DATA_W-1:0] disk_rdata_i
);

    typedef enum logic [2:0] {
        OCIOSO,
        ESPERA_GNT,
        LER,
        ESCREVE,
        FIM
    } state_t;

    state_t            state_q, state_d;
    logic              dir_q, dir_d;
    logic [ADDR_W-1:0] mbase_q, mbase_d;
    logic [DISK_W-1:0] dbase_q, dbase_d;
    logic [7:0]        offset_q, offset_d;
    logic [7:0]        rest_q, rest_d;
    // The last driven addresses are registered so that the ports hold their
    // value between accesses. The ports themselves are driven from the
    // next-state value, so a new address appears in the cycle that issues it.
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DISK_W-1:0] disk_addr_q, disk_addr_d;

    logic [ADDR_W-1:0] mem_cur;
    logic [DISK_W-1:0] disk_cur;

    // Base + offset wraps silently at the port width.
    assign mem_cur  = mbase_q + ADDR_W'(offset_q);
    assign disk_cur = dbase_q + DISK_W'(offset_q);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= OCIOSO;
            dir_q       <= 1'b0;
            mbase_q     <= '0;
            dbase_q     <= '0;
            offset_q    <= '0;
            rest_q      <= '0;
            mem_addr_q  <= '0;
            disk_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            mbase_q     <= mbase_d;
            dbase_q     <= dbase_d;
            offset_q    <= offset_d;
            rest_q      <= rest_d;
            mem_addr_q  <= mem_addr_d;
            disk_addr_q <= disk_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        mbase_d      = mbase_q;
        dbase_d      = dbase_q;
        offset_d     = offset_q;
        rest_d       = rest_q;
        mem_addr_d   = mem_addr_q;
        disk_addr_d  = disk_addr_q;
        concluido_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        disk_we_o    = 1'b0;
        mem_wdata_o  = '0;
        disk_wdata_o = '0;

        unique case (state_q)
            OCIOSO: begin
                if (iniciar_i) begin
                    dir_d    = direcao_i;
                    mbase_d  = end_mem_i;
                    dbase_d  = end_disco_i;
                    offset_d = '0;
                    if (tamanho_i == 8'd0) begin
                        state_d = FIM;
                    end else begin
                        rest_d  = tamanho_i;
                        state_d = ESPERA_GNT;
                    end
                end
            end
            ESPERA_GNT: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_d = LER;
            end
            LER: begin
                // Issue the source read; the data returns during ESCREVE.
                mem_req_o = 1'b1;
                if (dir_q) mem_addr_d  = mem_cur;
                else       disk_addr_d = disk_cur;
                state_d = ESCREVE;
            end
            ESCREVE: begin
                mem_req_o = 1'b1;
                if (dir_q) begin
                    disk_addr_d  = disk_cur;
                    disk_we_o    = 1'b1;
                    disk_wdata_o = mem_rdata_i;
                end else begin
                    mem_addr_d   = mem_cur;
                    mem_we_o     = 1'b1;
                    mem_wdata_o  = disk_rdata_i;
                end
                offset_d = offset_q + 8'd1;
                rest_d   = rest_q - 8'd1;
                if (rest_q == 8'd1)  state_d = FIM;
                else if (mem_gnt_i)  state_d = LER;
                else                 state_d = ESPERA_GNT;
            end
            FIM: begin
                concluido_o = 1'b1;
                state_d     = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    assign ocupado_o   = (state_q != OCIOSO);
    assign mem_addr_o  = mem_addr_d;
    assign disk_addr_o = disk_addr_d;

endmodule
